// File: rtl/jesd_map_pkg.sv
// jesd_map_pkg: capture FSM encoding and derived-width helpers shared by the JESD RX sample mapper
package jesd_map_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } cap_state_t;

   function automatic int calc_num_conv(input int num_lanes, input int lanes_per_conv);
      return num_lanes / lanes_per_conv;
   endfunction

   function automatic int calc_spl(input int lane_w);
      return lane_w / 8;
   endfunction

   function automatic int calc_sw(input int lanes_per_conv);
      return 8 * lanes_per_conv;
   endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// axis_skid_buf: two-entry buffer with a registered head entry, carrying data plus a last flag
module axis_skid_buf #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_last,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last
);

   logic [DATA_W:0] e0, e1;
   logic [1:0]      cnt;
   logic            push, pop;

   assign m_valid          = cnt != 2'd0;
   assign {m_last, m_data} = e0;
   assign pop              = m_valid && m_ready;
   assign s_ready          = cnt != 2'd2 || pop;
   assign push             = s_valid && s_ready;

   // e0 drives the output and only changes on a pop or into an empty buffer, so a stalled beat stays stable
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         e0  <= '0;
         e1  <= '0;
      end else begin
         cnt <= cnt + {1'b0, push} - {1'b0, pop};
         if (push && (cnt == 2'd0 || (cnt == 2'd1 && pop))) e0 <= {s_last, s_data};
         else if (pop && cnt == 2'd2) e0 <= e1;
         if (push && ((cnt == 2'd1 && !pop) || (cnt == 2'd2 && pop))) e1 <= {s_last, s_data};
      end
   end

endmodule

// File: rtl/jesd_rx_sample_mapper.sv
// jesd_rx_sample_mapper: regroups JESD RX lane bytes into per-converter I/Q samples with a bounded capture window
module jesd_rx_sample_mapper
   import jesd_map_pkg::*;
#(
   parameter int NUM_LANES      = 8,
   parameter int LANE_W         = 32,
   parameter int LANES_PER_CONV = 4,
   parameter int CAP_LEN_W      = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_LANES*LANE_W-1:0] rx_tdata,
   input  logic                        rx_tvalid,
   input  logic                        fmt_offset,
   input  logic                        swap_iq,
   input  logic                        cap_start,
   input  logic                        cap_stop,
   input  logic [CAP_LEN_W-1:0]        cap_len,
   output logic [NUM_LANES*LANE_W-1:0] m_tdata,
   output logic                        m_tvalid,
   input  logic                        m_tready,
   output logic                        m_tlast,
   output logic                        cap_busy,
   output logic                        cap_done,
   output logic                        ovf,
   input  logic                        ovf_clr
);

   localparam int NUM_CONV = calc_num_conv(NUM_LANES, LANES_PER_CONV);
   localparam int SPL      = calc_spl(LANE_W);
   localparam int SW       = calc_sw(LANES_PER_CONV);
   localparam int HW       = SW / 2;
   localparam int CW       = LANES_PER_CONV * LANE_W;
   localparam int DW       = NUM_LANES * LANE_W;

   cap_state_t           state;
   logic [DW-1:0]        mapped, s1_data;
   logic [SW-1:0]        word;
   logic [HW-1:0]        i_c, q_c;
   logic [CAP_LEN_W-1:0] len_q, cnt;
   logic                 s1_valid, s1_last, sk_ready, stop_pend;
   logic                 can_take, rx_acc, last_beat, out_last_hs;

   assign can_take    = !s1_valid || sk_ready;
   assign rx_acc      = state == ST_RUN && rx_tvalid && can_take;
   assign last_beat   = (len_q != '0) ? (cnt == len_q - CAP_LEN_W'(1)) : stop_pend;
   assign out_last_hs = m_tvalid && m_tready && m_tlast;

   // gather byte k of each converter's lanes into one word, convert format, swap, and pack converter 0 highest
   always_comb begin
      mapped = '0;
      word   = '0;
      i_c    = '0;
      q_c    = '0;
      for (int c = 0; c < NUM_CONV; c++) begin
         for (int k = 0; k < SPL; k++) begin
            for (int j = 0; j < LANES_PER_CONV; j++)
               word[(LANES_PER_CONV-1-j)*8 +: 8] = rx_tdata[(c*LANES_PER_CONV+j)*LANE_W + k*8 +: 8];
            i_c = word[SW-1 -: HW] ^ {fmt_offset, {(HW-1){1'b0}}};
            q_c = word[HW-1:0] ^ {fmt_offset, {(HW-1){1'b0}}};
            mapped[(NUM_CONV-1-c)*CW + CW/2 + k*HW +: HW] = swap_iq ? q_c : i_c;
            mapped[(NUM_CONV-1-c)*CW + k*HW +: HW]        = swap_iq ? i_c : q_c;
         end
      end
   end

   // stage 1 holds one mapped beat; it refills whenever it is empty or is handing its beat to the buffer
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_last  <= 1'b0;
      end else if (can_take) begin
         s1_valid <= rx_acc;
         if (rx_acc) begin
            s1_data <= mapped;
            s1_last <= last_beat;
         end
      end
   end

   axis_skid_buf #(
      .DATA_W(DW)
   ) u_skid (
      .clk    (clk),
      .rst    (rst),
      .s_valid(s1_valid),
      .s_ready(sk_ready),
      .s_data (s1_data),
      .s_last (s1_last),
      .m_valid(m_tvalid),
      .m_ready(m_tready),
      .m_data (m_tdata),
      .m_last (m_tlast)
   );

   // capture window control: counts accepted beats, tags the final one, and flags beats lost to a full pipeline
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         len_q     <= '0;
         cnt       <= '0;
         stop_pend <= 1'b0;
         cap_busy  <= 1'b0;
         cap_done  <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         cap_done <= out_last_hs;
         ovf      <= (state == ST_RUN && rx_tvalid && !can_take) ? 1'b1 : ovf_clr ? 1'b0 : ovf;
         case (state)
            ST_IDLE: if (cap_start) begin
               state     <= ST_RUN;
               cap_busy  <= 1'b1;
               len_q     <= cap_len;
               cnt       <= '0;
               stop_pend <= 1'b0;
            end
            ST_RUN: begin
               if (rx_acc) cnt <= cnt + CAP_LEN_W'(1);
               if (cap_stop && len_q == '0) stop_pend <= 1'b1;
               if (rx_acc && last_beat) state <= ST_DRAIN;
            end
            ST_DRAIN: if (out_last_hs) begin
               state    <= ST_IDLE;
               cap_busy <= 1'b0;
            end
            default: begin
               state    <= ST_IDLE;
               cap_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jesd_rx_sample_mapper.sv
// tb_jesd_rx_sample_mapper: table vectors, capture corner sequences and a randomized model comparison
module tb_jesd_rx_sample_mapper;

   localparam int DW = 256;

   typedef struct {
      string         name;
      logic [DW-1:0] d;
      logic          fmt;
      logic          swp;
      int            lo;
      logic [15:0]   exp;
   } vec_t;

   typedef struct {
      logic [DW-1:0] d;
      logic          l;
      int            t;
   } beat_t;

   logic          clk = 1'b0, rst = 1'b1;
   logic [DW-1:0] rx_tdata = '0;
   logic          rx_tvalid = 1'b0, fmt_offset = 1'b0, swap_iq = 1'b0;
   logic          cap_start = 1'b0, cap_stop = 1'b0, m_tready = 1'b0, ovf_clr = 1'b0;
   logic [15:0]   cap_len = '0;
   logic [DW-1:0] m_tdata;
   logic          m_tvalid, m_tlast, cap_busy, cap_done, ovf;
   int            n_vec = 0, n_bad = 0;

   always #5 clk = ~clk;

   jesd_rx_sample_mapper dut (
      .clk       (clk),
      .rst       (rst),
      .rx_tdata  (rx_tdata),
      .rx_tvalid (rx_tvalid),
      .fmt_offset(fmt_offset),
      .swap_iq   (swap_iq),
      .cap_start (cap_start),
      .cap_stop  (cap_stop),
      .cap_len   (cap_len),
      .m_tdata   (m_tdata),
      .m_tvalid  (m_tvalid),
      .m_tready  (m_tready),
      .m_tlast   (m_tlast),
      .cap_busy  (cap_busy),
      .cap_done  (cap_done),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr)
   );

   task automatic chk_b(input string name, input logic got, input logic exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", name, got, exp);
      end
   endtask

   task automatic chk_w(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic chk_i(input string name, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // each output sample is the big-endian join of one byte from every lane of its converter
   function automatic logic [DW-1:0] ref_map(input logic [DW-1:0] d, input logic fmt, input logic swp);
      logic [DW-1:0] r;
      logic [31:0]   w;
      logic [15:0]   i_v, q_v, t;
      r = '0;
      for (int c = 0; c < 2; c++) begin
         for (int k = 0; k < 4; k++) begin
            w = '0;
            for (int j = 0; j < 4; j++) w = (w << 8) | 32'(d[(c*4+j)*32 + k*8 +: 8]);
            i_v = w[31:16];
            q_v = w[15:0];
            if (fmt) begin
               i_v = i_v ^ 16'h8000;
               q_v = q_v ^ 16'h8000;
            end
            if (swp) begin
               t   = i_v;
               i_v = q_v;
               q_v = t;
            end
            r[(1-c)*128 + 64 + k*16 +: 16] = i_v;
            r[(1-c)*128 + k*16 +: 16]      = q_v;
         end
      end
      return r;
   endfunction

   function automatic logic [DW-1:0] rand256();
      logic [DW-1:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; rx_tvalid = 1'b0; cap_start = 1'b0; cap_stop = 1'b0; ovf_clr = 1'b0;
      m_tready = 1'b0; fmt_offset = 1'b0; swap_iq = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_beat(input logic [DW-1:0] d, input logic f, input logic s,
                           output logic [DW-1:0] got, output logic lst, output logic seen);
      @(negedge clk);
      cap_len = 16'd1; cap_start = 1'b1; m_tready = 1'b1;
      @(negedge clk);
      cap_start = 1'b0; rx_tvalid = 1'b1; rx_tdata = d; fmt_offset = f; swap_iq = s;
      @(negedge clk);
      rx_tvalid = 1'b0; fmt_offset = 1'b0; swap_iq = 1'b0;
      seen = 1'b0; got = '0; lst = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         if (m_tvalid) begin
            seen = 1'b1;
            got  = m_tdata;
            lst  = m_tlast;
         end else @(negedge clk);
      end
      repeat (3) @(negedge clk);
   endtask

   vec_t          tbl[12];
   logic [DW-1:0] pa, l0ff, bd[16], got, tl_data;
   logic          lst, seen, exp_v, pop, acc, drop, head_last, ovf_m, done_m, busy_m, stop_p, done_seen;
   int            n_out, first_at, last_at, tlast_cyc, done_at, st, cnt, len;
   beat_t         q[$];

   initial begin
      pa = '0;
      for (int l = 0; l < 8; l++)
         for (int k = 0; k < 4; k++) pa[l*32 + k*8 +: 8] = 8'(l*16 + k);
      l0ff = '0;
      l0ff[31:0] = 32'hFFFF_FFFF;
      for (int i = 0; i < 16; i++) bd[i] = rand256();
      tbl[0]  = '{"conv0_i3",       pa,   1'b0, 1'b0, 240, 16'h0313};
      tbl[1]  = '{"conv0_i0",       pa,   1'b0, 1'b0, 192, 16'h0010};
      tbl[2]  = '{"conv0_q0",       pa,   1'b0, 1'b0, 128, 16'h2030};
      tbl[3]  = '{"conv1_i0",       pa,   1'b0, 1'b0,  64, 16'h4050};
      tbl[4]  = '{"conv1_q0",       pa,   1'b0, 1'b0,   0, 16'h6070};
      tbl[5]  = '{"swap_i0",        pa,   1'b0, 1'b1, 192, 16'h2030};
      tbl[6]  = '{"offs_i3",        pa,   1'b1, 1'b0, 240, 16'h8313};
      tbl[7]  = '{"offs_zero_lo",   '0,   1'b1, 1'b0,   0, 16'h8000};
      tbl[8]  = '{"offs_zero_hi",   '0,   1'b1, 1'b0, 240, 16'h8000};
      tbl[9]  = '{"offs_swap_q0",   l0ff, 1'b1, 1'b1, 128, 16'h7F00};
      tbl[10] = '{"offs_swap_q3",   l0ff, 1'b1, 1'b1, 176, 16'h7F00};
      tbl[11] = '{"offs_swap_i0",   l0ff, 1'b1, 1'b1, 192, 16'h8000};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk_b("rst_m_tvalid", m_tvalid, 1'b0);
      chk_w("rst_m_tdata", m_tdata, '0);
      chk_b("rst_m_tlast", m_tlast, 1'b0);
      chk_b("rst_cap_busy", cap_busy, 1'b0);
      chk_b("rst_cap_done", cap_done, 1'b0);
      chk_b("rst_ovf", ovf, 1'b0);

      foreach (tbl[v]) begin
         run_beat(tbl[v].d, tbl[v].fmt, tbl[v].swp, got, lst, seen);
         chk_b({tbl[v].name, "_seen"}, seen, 1'b1);
         chk_w(tbl[v].name, DW'(got[tbl[v].lo +: 16]), DW'(tbl[v].exp));
         chk_w({tbl[v].name, "_word"}, got, ref_map(tbl[v].d, tbl[v].fmt, tbl[v].swp));
         chk_b({tbl[v].name, "_last"}, lst, 1'b1);
      end

      // fixed-length capture: ten offered beats, four kept
      @(negedge clk);
      cap_len = 16'd4; cap_start = 1'b1; m_tready = 1'b1;
      @(negedge clk);
      cap_start = 1'b0;
      n_out = 0; first_at = -1; last_at = -1; tlast_cyc = -1; done_at = -1; tl_data = '0;
      for (int i = 0; i < 16; i++) begin
         if (m_tvalid) begin
            n_out++;
            if (first_at < 0) first_at = i;
            if (m_tlast) begin
               last_at   = n_out;
               tlast_cyc = i;
               tl_data   = m_tdata;
            end
         end
         if (cap_done) done_at = i;
         rx_tvalid = i < 10;
         rx_tdata  = bd[i];
         @(negedge clk);
      end
      rx_tvalid = 1'b0;
      chk_i("len4_outputs", n_out, 4);
      chk_i("len4_first_latency", first_at, 2);
      chk_i("len4_tlast_index", last_at, 4);
      chk_i("len4_tlast_cycle", tlast_cyc, 5);
      chk_i("len4_done_cycle", done_at, 6);
      chk_w("len4_last_data", tl_data, ref_map(bd[3], 1'b0, 1'b0));
      chk_b("len4_ovf", ovf, 1'b0);
      chk_b("len4_busy_end", cap_busy, 1'b0);

      // continuous capture against a stalled sink: three beats fit, the fourth overflows
      @(negedge clk);
      cap_len = 16'd0; cap_start = 1'b1; m_tready = 1'b0;
      @(negedge clk);
      cap_start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (i == 3) chk_b("stall_ovf_before", ovf, 1'b0);
         if (i == 4) chk_b("stall_ovf_after", ovf, 1'b1);
         if (i == 5) begin
            chk_b("stall_valid", m_tvalid, 1'b1);
            chk_w("stall_hold", m_tdata, ref_map(bd[0], 1'b0, 1'b0));
         end
         rx_tvalid = 1'b1;
         rx_tdata  = bd[i];
         @(negedge clk);
      end
      rx_tvalid = 1'b0;
      m_tready  = 1'b1;
      n_out = 0;
      for (int i = 0; i < 10; i++) begin
         if (m_tvalid) begin
            if (n_out < 3) chk_w($sformatf("stall_out%0d", n_out), m_tdata, ref_map(bd[n_out], 1'b0, 1'b0));
            chk_b("stall_out_nolast", m_tlast, 1'b0);
            n_out++;
         end
         @(negedge clk);
      end
      chk_i("stall_out_count", n_out, 3);
      cap_stop = 1'b1;
      @(negedge clk);
      cap_stop = 1'b0; rx_tvalid = 1'b1; rx_tdata = bd[6];
      @(negedge clk);
      rx_tvalid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         if (m_tvalid) begin
            seen = 1'b1;
            chk_b("stop_last", m_tlast, 1'b1);
            chk_w("stop_data", m_tdata, ref_map(bd[6], 1'b0, 1'b0));
         end else @(negedge clk);
      end
      chk_b("stop_seen", seen, 1'b1);
      repeat (3) @(negedge clk);
      chk_b("stop_idle", cap_busy, 1'b0);
      chk_b("ovf_sticky", ovf, 1'b1);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      chk_b("ovf_cleared", ovf, 1'b0);

      // reset in the middle of a capture while a beat is on the output
      @(negedge clk);
      cap_len = 16'd0; cap_start = 1'b1; m_tready = 1'b0;
      @(negedge clk);
      cap_start = 1'b0; rx_tvalid = 1'b1; rx_tdata = bd[7];
      repeat (3) @(negedge clk);
      chk_b("pre_rst_valid", m_tvalid, 1'b1);
      rst = 1'b1; rx_tvalid = 1'b0;
      @(negedge clk);
      rst = 1'b0; m_tready = 1'b1;
      chk_b("mid_rst_m_tvalid", m_tvalid, 1'b0);
      chk_w("mid_rst_m_tdata", m_tdata, '0);
      chk_b("mid_rst_m_tlast", m_tlast, 1'b0);
      chk_b("mid_rst_cap_busy", cap_busy, 1'b0);
      chk_b("mid_rst_ovf", ovf, 1'b0);
      done_seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         done_seen = done_seen | cap_done;
         @(negedge clk);
      end
      chk_b("mid_rst_no_done", done_seen, 1'b0);
      cap_len = 16'd2; cap_start = 1'b1;
      @(negedge clk);
      cap_start = 1'b0;
      chk_b("restart_busy", cap_busy, 1'b1);

      // randomized traffic against a FIFO-with-latency model of the capture rules
      do_reset();
      st = 0; cnt = 0; len = 0; stop_p = 1'b0; ovf_m = 1'b0; done_m = 1'b0; busy_m = 1'b0;
      q.delete();
      for (int n = 0; n < 2000; n++) begin
         exp_v = q.size() > 0 && n >= q[0].t + 2;
         chk_b("rnd_m_tvalid", m_tvalid, exp_v);
         chk_b("rnd_cap_busy", cap_busy, busy_m);
         chk_b("rnd_cap_done", cap_done, done_m);
         chk_b("rnd_ovf", ovf, ovf_m);
         if (exp_v && m_tvalid) begin
            chk_w("rnd_m_tdata", m_tdata, q[0].d);
            chk_b("rnd_m_tlast", m_tlast, q[0].l);
         end
         rx_tvalid  = $urandom_range(0, 3) != 0;
         rx_tdata   = rand256();
         fmt_offset = 1'($urandom_range(0, 1));
         swap_iq    = 1'($urandom_range(0, 1));
         m_tready   = $urandom_range(0, 3) < ((n / 250) % 4 + 1);
         cap_start  = $urandom_range(0, 15) == 0;
         cap_stop   = $urandom_range(0, 7) == 0;
         cap_len    = 16'($urandom_range(0, 5));
         ovf_clr    = $urandom_range(0, 7) == 0;
         pop       = exp_v && m_tready;
         acc       = st == 1 && rx_tvalid && (int'(q.size()) - int'(pop)) < 3;
         drop      = st == 1 && rx_tvalid && !acc;
         head_last = pop && q[0].l;
         done_m    = head_last;
         if (drop) ovf_m = 1'b1;
         else if (ovf_clr) ovf_m = 1'b0;
         if (st == 0) begin
            if (cap_start) begin
               st = 1; len = int'(cap_len); cnt = 0; stop_p = 1'b0;
            end
         end else if (st == 1) begin
            if (acc) begin
               lst = (len != 0) ? (cnt + 1 == len) : stop_p;
               cnt++;
               q.push_back('{ref_map(rx_tdata, fmt_offset, swap_iq), lst, n});
               if (lst) st = 2;
            end
            if (cap_stop && len == 0) stop_p = 1'b1;
         end else if (head_last) st = 0;
         if (pop) void'(q.pop_front());
         busy_m = st != 0;
         @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
